seq_controller: RTL and testbench

- Next-generation instruction sequencer for the 8-phase 3-bit-opcode RISC core.
- Integrates the phase counter with the control decode and adds new behaviour:
  - memory wait-state handshake with timeout/bus error
  - run/single-step mode
  - latched halt state with resume
  - retired-instruction counter
- Sits between the IR/ALU flags and the datapath strobes; replaces the external phase counter.

---
 rtl/risc_pkg.sv | 49 ++++
 rtl/seq_decode.sv | 61 ++++++
 rtl/seq_controller.sv | 166 ++++++++++++++++
 tb/tb_seq_controller.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 8-phase, 3-bit-opcode RISC sequencer:
//   - opcode encodings (HLT..JMP)
//   - named phases used by the sequencer (end of fetch, end of execute,
//     halt decision phase)
//   - sequencer state enum and the packed datapath-strobe bundle
//   - is_aluop(): opcodes whose result comes through the ALU path
// ---------------------------------------------------------------------------
package risc_pkg;

  // Opcode encodings
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Phases with special meaning to the sequencer
  localparam logic [2:0] P_FETCH_LAST = 3'd3;  // last instruction-fetch phase (may wait)
  localparam logic [2:0] P_EXEC_LAST  = 3'd7;  // last execute phase (may wait, retires)
  localparam logic [2:0] P_HLT        = 3'd4;  // phase where HLT takes effect

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_e;

  // Datapath strobes, MSB first in the order they appear on the port list
  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic halt;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic wr;
    logic data_e;
  } ctrl_t;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/seq_decode.sv
// ---------------------------------------------------------------------------
// seq_decode
// Purely combinational control decode: maps (phase, opcode, zero) to the nine
// datapath strobes. Only meaningful while the sequencer is in RUN; the parent
// overrides the result in HALTED.
// Ports:
//   i_phase  [2:0]  current phase
//   i_opcode [2:0]  current IR opcode
//   i_zero          accumulator-zero flag
//   o_ctrl   ctrl_t decoded strobes
// ---------------------------------------------------------------------------
module seq_decode
  import risc_pkg::*;
(
  input  logic [2:0] i_phase,
  input  logic [2:0] i_opcode,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  logic w_alu;

  assign w_alu = is_aluop(i_opcode);

  always_comb begin
    o_ctrl = '0;
    case (i_phase)
      3'd0: o_ctrl.sel = 1'b1;
      3'd1: begin
        o_ctrl.sel = 1'b1;
        o_ctrl.rd  = 1'b1;
      end
      3'd2, 3'd3: begin
        o_ctrl.sel   = 1'b1;
        o_ctrl.rd    = 1'b1;
        o_ctrl.ld_ir = 1'b1;
      end
      3'd4: begin
        o_ctrl.inc_pc = 1'b1;
        o_ctrl.halt   = (i_opcode == HLT);
      end
      3'd5: o_ctrl.rd = w_alu;
      3'd6: begin
        o_ctrl.rd     = w_alu;
        // SKZ skips the next instruction by a second PC increment
        o_ctrl.inc_pc = (i_opcode == SKZ) && i_zero;
        o_ctrl.ld_pc  = (i_opcode == JMP);
        o_ctrl.data_e = (i_opcode == STO);
      end
      3'd7: begin
        o_ctrl.rd     = w_alu;
        o_ctrl.ld_ac  = w_alu;
        o_ctrl.ld_pc  = (i_opcode == JMP);
        o_ctrl.wr     = (i_opcode == STO);
        o_ctrl.data_e = (i_opcode == STO);
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/seq_controller.sv
// ---------------------------------------------------------------------------
// seq_controller
// Instruction sequencer for the 8-phase RISC core: phase counter, RUN/HALTED
// FSM, memory wait-state handling with timeout, run/single-step control and a
// retired-instruction counter. Control strobes come from seq_decode and are
// forced to "halt only" while HALTED.
// Parameters:
//   CNT_W    width of instr_count (wraps)
//   WAIT_EN  1: stall phases 3/7 on mem_ready=0; 0: never stall
//   WAIT_MAX stall cycles tolerated before bus error (1..255)
// Ports:
//   clk, rst (async, active high)
//   opcode[2:0], zero          IR opcode and accumulator-zero flag
//   mem_ready                  memory completes this cycle
//   run, step, resume          mode / single-step start / leave HALTED
//   sel rd ld_ir halt inc_pc ld_pc ld_ac wr data_e   datapath strobes
//   phase[2:0]                 current phase
//   bus_err                    sticky wait-timeout flag
//   instr_count[CNT_W-1:0]     instructions completed since reset
// ---------------------------------------------------------------------------
module seq_controller
  import risc_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_EN  = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             run,
  input  logic             step,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic [2:0]       phase,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int                 STALL_W   = $clog2(WAIT_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WAIT_MAX);

  seq_state_e         r_state, w_state_next;
  logic [2:0]         r_phase, w_phase_next;
  logic [STALL_W-1:0] r_stall, w_stall_next;
  logic               r_bus_err, w_bus_err_next;
  logic [CNT_W-1:0]   r_count, w_count_next;

  ctrl_t w_dec;
  ctrl_t w_ctrl;
  logic  w_stall_req;

  seq_decode u_decode (
    .i_phase  (r_phase),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_ctrl   (w_dec)
  );

  // Memory wait only at the end of a fetch or execute phase that actually
  // touches memory. mem_ready only reaches outputs via r_phase.
  assign w_stall_req = (WAIT_EN != 0)
                     && ((r_phase == P_FETCH_LAST) || (r_phase == P_EXEC_LAST))
                     && (w_dec.rd || w_dec.wr)
                     && !mem_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_phase   <= 3'd0;
      r_stall   <= '0;
      r_bus_err <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_phase   <= w_phase_next;
      r_stall   <= w_stall_next;
      r_bus_err <= w_bus_err_next;
      r_count   <= w_count_next;
    end
  end

  // Next-state logic; priority: HLT entry, then wait/timeout, then step hold,
  // then normal advance.
  always_comb begin
    w_state_next   = r_state;
    w_phase_next   = r_phase;
    w_stall_next   = r_stall;
    w_bus_err_next = r_bus_err;
    w_count_next   = r_count;
    case (r_state)
      RUN: begin
        if ((r_phase == P_HLT) && (opcode == HLT)) begin
          w_state_next = HALTED;
          w_phase_next = 3'd0;
          w_stall_next = '0;
        end else if (w_stall_req) begin
          if (r_stall == STALL_MAX) begin
            w_bus_err_next = 1'b1;
            w_state_next   = HALTED;
            w_phase_next   = 3'd0;
            w_stall_next   = '0;
          end else begin
            w_stall_next = r_stall + STALL_W'(1);
          end
        end else if ((r_phase == 3'd0) && !run && !step) begin
          // single-step mode waiting for a step request
          w_phase_next = 3'd0;
        end else begin
          w_phase_next = r_phase + 3'd1;
          w_stall_next = '0;
          if (r_phase == P_EXEC_LAST) begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      HALTED: begin
        w_phase_next = 3'd0;
        w_stall_next = '0;
        // a bus error can only be cleared by reset
        if (resume && !r_bus_err) begin
          w_state_next = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
        w_phase_next = 3'd0;
        w_stall_next = '0;
      end
    endcase
  end

  // Output override while halted
  always_comb begin
    w_ctrl = w_dec;
    if (r_state == HALTED) begin
      w_ctrl      = '0;
      w_ctrl.halt = 1'b1;
    end
  end

  assign sel         = w_ctrl.sel;
  assign rd          = w_ctrl.rd;
  assign ld_ir       = w_ctrl.ld_ir;
  assign halt        = w_ctrl.halt;
  assign inc_pc      = w_ctrl.inc_pc;
  assign ld_pc       = w_ctrl.ld_pc;
  assign ld_ac       = w_ctrl.ld_ac;
  assign wr          = w_ctrl.wr;
  assign data_e      = w_ctrl.data_e;
  assign phase       = r_phase;
  assign bus_err     = r_bus_err;
  assign instr_count = r_count;

endmodule

// File: tb/tb_seq_controller.sv
// ---------------------------------------------------------------------------
// tb_seq_controller
// Self-checking bench for seq_controller (WAIT_MAX=4): a table of hand-derived
// vectors for ADD/SKZ instructions, directed sequences for wait states, HLT,
// single-step, async reset and bus timeout, then randomized stimulus compared
// against a behavioural model of the sequencing rules.
// Control vectors are {sel,rd,ld_ir,halt,inc_pc,ld_pc,ld_ac,wr,data_e}.
// ---------------------------------------------------------------------------
module tb_seq_controller;

  localparam int T_WAIT_MAX = 4;

  localparam logic [2:0] T_HLT = 3'd0, T_SKZ = 3'd1, T_ADD = 3'd2, T_AND = 3'd3;
  localparam logic [2:0] T_XOR = 3'd4, T_LDA = 3'd5, T_STO = 3'd6, T_JMP = 3'd7;

  localparam logic [8:0] C_P0     = 9'b100000000;
  localparam logic [8:0] C_P1     = 9'b110000000;
  localparam logic [8:0] C_FETCH  = 9'b111000000;
  localparam logic [8:0] C_INC    = 9'b000010000;
  localparam logic [8:0] C_RD     = 9'b010000000;
  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_ALU7   = 9'b010000100;
  localparam logic [8:0] C_HLT4   = 9'b000110000;
  localparam logic [8:0] C_HALTED = 9'b000100000;
  localparam logic [8:0] C_STO7   = 9'b000000011;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic        zero, mem_ready, run, step, resume;
  logic        sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
  logic [2:0]  phase;
  logic        bus_err;
  logic [15:0] instr_count;
  logic [8:0]  dut_ctrl;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit m_halted;
  int m_phase, m_stall, m_count;
  bit m_bus_err;

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic [2:0]  ph;
    logic [8:0]  ctrl;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[24];

  seq_controller #(.CNT_W(16), .WAIT_EN(1), .WAIT_MAX(T_WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .run(run), .step(step), .resume(resume),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e),
    .phase(phase), .bus_err(bus_err), .instr_count(instr_count)
  );

  assign dut_ctrl = {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected strobes from the instruction-phase table
  function automatic logic [8:0] model_ctrl();
    bit alu, s, r, l, h, ip, lp, la, w, de;
    if (m_halted) return C_HALTED;
    alu = opcode inside {T_ADD, T_AND, T_XOR, T_LDA};
    {s, r, l, h, ip, lp, la, w, de} = '0;
    if (m_phase <= 3) s = 1;
    if (m_phase >= 1 && m_phase <= 3) r = 1;
    if (m_phase == 2 || m_phase == 3) l = 1;
    if (m_phase == 4) begin ip = 1; h = (opcode == T_HLT); end
    if (m_phase >= 5) r = alu;
    if (m_phase == 6) begin ip = (opcode == T_SKZ) && zero; lp = (opcode == T_JMP); de = (opcode == T_STO); end
    if (m_phase == 7) begin la = alu; lp = (opcode == T_JMP); w = (opcode == T_STO); de = (opcode == T_STO); end
    return {s, r, l, h, ip, lp, la, w, de};
  endfunction

  task automatic model_reset();
    m_halted = 0; m_phase = 0; m_stall = 0; m_count = 0; m_bus_err = 0;
  endtask

  task automatic model_step();
    logic [8:0] c;
    bit mem_op;
    c = model_ctrl();
    mem_op = c[7] | c[1];
    if (m_halted) begin
      if (resume && !m_bus_err) begin m_halted = 0; m_phase = 0; end
    end else if (m_phase == 4 && opcode == T_HLT) begin
      m_halted = 1; m_phase = 0; m_stall = 0;
    end else if ((m_phase == 3 || m_phase == 7) && mem_op && !mem_ready) begin
      if (m_stall == T_WAIT_MAX) begin
        m_bus_err = 1; m_halted = 1; m_phase = 0; m_stall = 0;
      end else m_stall++;
    end else if (m_phase == 0 && !run && !step) begin
      // waiting for step
    end else begin
      if (m_phase == 7) m_count = (m_count + 1) % 65536;
      m_phase = (m_phase + 1) % 8;
      m_stall = 0;
    end
  endtask

  // One clock: model follows the inputs currently applied
  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_to(input int ph);
    for (int k = 0; k < 16 && phase != 3'(ph); k++) advance();
    chk("run_to_phase", 32'(phase), 32'(ph));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{T_ADD, 1'b0, 3'd0, C_P0,    16'd0};
    tbl[1]  = '{T_ADD, 1'b0, 3'd1, C_P1,    16'd0};
    tbl[2]  = '{T_ADD, 1'b0, 3'd2, C_FETCH, 16'd0};
    tbl[3]  = '{T_ADD, 1'b0, 3'd3, C_FETCH, 16'd0};
    tbl[4]  = '{T_ADD, 1'b0, 3'd4, C_INC,   16'd0};
    tbl[5]  = '{T_ADD, 1'b0, 3'd5, C_RD,    16'd0};
    tbl[6]  = '{T_ADD, 1'b0, 3'd6, C_RD,    16'd0};
    tbl[7]  = '{T_ADD, 1'b0, 3'd7, C_ALU7,  16'd0};
    tbl[8]  = '{T_SKZ, 1'b1, 3'd0, C_P0,    16'd1};
    tbl[9]  = '{T_SKZ, 1'b1, 3'd1, C_P1,    16'd1};
    tbl[10] = '{T_SKZ, 1'b1, 3'd2, C_FETCH, 16'd1};
    tbl[11] = '{T_SKZ, 1'b1, 3'd3, C_FETCH, 16'd1};
    tbl[12] = '{T_SKZ, 1'b1, 3'd4, C_INC,   16'd1};
    tbl[13] = '{T_SKZ, 1'b1, 3'd5, C_NONE,  16'd1};
    tbl[14] = '{T_SKZ, 1'b1, 3'd6, C_INC,   16'd1};
    tbl[15] = '{T_SKZ, 1'b1, 3'd7, C_NONE,  16'd1};
    tbl[16] = '{T_SKZ, 1'b0, 3'd0, C_P0,    16'd2};
    tbl[17] = '{T_SKZ, 1'b0, 3'd1, C_P1,    16'd2};
    tbl[18] = '{T_SKZ, 1'b0, 3'd2, C_FETCH, 16'd2};
    tbl[19] = '{T_SKZ, 1'b0, 3'd3, C_FETCH, 16'd2};
    tbl[20] = '{T_SKZ, 1'b0, 3'd4, C_INC,   16'd2};
    tbl[21] = '{T_SKZ, 1'b0, 3'd5, C_NONE,  16'd2};
    tbl[22] = '{T_SKZ, 1'b0, 3'd6, C_NONE,  16'd2};
    tbl[23] = '{T_SKZ, 1'b0, 3'd7, C_NONE,  16'd2};

    rst = 1'b1; opcode = T_ADD; zero = 1'b0; mem_ready = 1'b1;
    run = 1'b1; step = 1'b0; resume = 1'b0;
    #2;
    chk("async_reset_phase", 32'(phase), 32'd0);
    do_reset();
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_ctrl", 32'(dut_ctrl), 32'(C_P0));
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);

    // ---- table: ADD, SKZ zero=1, SKZ zero=0 in free-run ----
    for (int i = 0; i < 24; i++) begin
      opcode = tbl[i].op; zero = tbl[i].z;
      #1;
      $display("vec %0d op=%0d z=%0b ph=%0d ctrl=%b cnt=%0d", i, opcode, zero, phase, dut_ctrl, instr_count);
      chk("tbl_phase", 32'(phase), 32'(tbl[i].ph));
      chk("tbl_ctrl", 32'(dut_ctrl), 32'(tbl[i].ctrl));
      chk("tbl_count", 32'(instr_count), 32'(tbl[i].cnt));
      advance();
    end
    chk("tbl_end_phase", 32'(phase), 32'd0);
    chk("tbl_end_count", 32'(instr_count), 32'd3);

    // ---- LDA with 3 wait cycles at phase 7 ----
    opcode = T_LDA; zero = 1'b0;
    run_to(7);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("lda_wait %0d ph=%0d ctrl=%b", k, phase, dut_ctrl);
      chk("lda_wait_phase", 32'(phase), 32'd7);
      chk("lda_wait_ctrl", 32'(dut_ctrl), 32'(C_ALU7));
      advance();
    end
    mem_ready = 1'b1;
    chk("lda_after_wait_phase", 32'(phase), 32'd7);
    advance();
    chk("lda_done_phase", 32'(phase), 32'd0);
    chk("lda_done_count", 32'(instr_count), 32'd4);
    chk("lda_bus_err", 32'(bus_err), 32'd0);

    // ---- HLT; resume coincident with HLT entry is ignored ----
    opcode = T_HLT;
    run_to(4);
    resume = 1'b1;
    #1;
    chk("hlt_p4_ctrl", 32'(dut_ctrl), 32'(C_HLT4));
    advance();
    resume = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("halted %0d ph=%0d ctrl=%b", k, phase, dut_ctrl);
      chk("halted_phase", 32'(phase), 32'd0);
      chk("halted_ctrl", 32'(dut_ctrl), 32'(C_HALTED));
      advance();
    end
    chk("halted_count", 32'(instr_count), 32'd4);
    resume = 1'b1;
    advance();
    resume = 1'b0;
    opcode = T_ADD;
    #1;
    chk("resume_phase", 32'(phase), 32'd0);
    chk("resume_ctrl", 32'(dut_ctrl), 32'(C_P0));
    advance();
    chk("resume_next_phase", 32'(phase), 32'd1);
    run_to(0);
    chk("after_resume_count", 32'(instr_count), 32'd5);

    // ---- single-step mode ----
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      advance();
      chk("step_idle_phase", 32'(phase), 32'd0);
      chk("step_idle_ctrl", 32'(dut_ctrl), 32'(C_P0));
    end
    step = 1'b1;
    advance();
    step = 1'b0;
    chk("step_start_phase", 32'(phase), 32'd1);
    for (int k = 0; k < 7; k++) advance();
    chk("step_done_phase", 32'(phase), 32'd0);
    chk("step_done_count", 32'(instr_count), 32'd6);
    advance(); advance();
    chk("step_wait_phase", 32'(phase), 32'd0);
    chk("step_wait_count", 32'(instr_count), 32'd6);
    step = 1'b1;
    advance();
    step = 1'b0;
    for (int k = 0; k < 4; k++) advance();
    chk("step_mid_phase", 32'(phase), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_phase", 32'(phase), 32'd0);
    chk("async_rst_ctrl", 32'(dut_ctrl), 32'(C_P0));
    chk("async_rst_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run = 1'b1;

    // ---- STO timeout: mem_ready stuck low at phase 7 ----
    opcode = T_STO;
    run_to(7);
    chk("sto_p7_ctrl", 32'(dut_ctrl), 32'(C_STO7));
    mem_ready = 1'b0;
    for (int k = 0; k < T_WAIT_MAX; k++) begin
      advance();
      chk("sto_stall_phase", 32'(phase), 32'd7);
      chk("sto_stall_bus_err", 32'(bus_err), 32'd0);
    end
    advance();
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_ctrl", 32'(dut_ctrl), 32'(C_HALTED));
    chk("timeout_phase", 32'(phase), 32'd0);
    mem_ready = 1'b1;
    resume = 1'b1;
    advance();
    resume = 1'b0;
    advance();
    chk("timeout_resume_ignored", 32'(dut_ctrl), 32'(C_HALTED));
    chk("timeout_sticky", 32'(bus_err), 32'd1);
    do_reset();
    chk("rst_clears_bus_err", 32'(bus_err), 32'd0);
    chk("rst_clears_ctrl", 32'(dut_ctrl), 32'(C_P0));

    // ---- randomized run against the model ----
    do_reset();
    for (int c = 0; c < 800; c++) begin
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      run    = ($urandom_range(0, 3) != 0);
      step   = ($urandom_range(0, 2) == 0);
      resume = ($urandom_range(0, 3) == 0);
      if (((c / 50) % 4) == 3) mem_ready = ($urandom_range(0, 9) == 0);
      else                     mem_ready = ($urandom_range(0, 7) != 0);
      #1;
      $display("rnd %0d op=%0d run=%0b step=%0b mr=%0b res=%0b ph=%0d ctrl=%b err=%0b cnt=%0d",
               c, opcode, run, step, mem_ready, resume, phase, dut_ctrl, bus_err, instr_count);
      chk("rnd_phase", 32'(phase), 32'(m_phase));
      chk("rnd_ctrl", 32'(dut_ctrl), 32'(model_ctrl()));
      chk("rnd_bus_err", 32'(bus_err), 32'(m_bus_err));
      chk("rnd_count", 32'(instr_count), 32'(m_count));
      if (m_bus_err && $urandom_range(0, 7) == 0) do_reset();
      else advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
